// File: rtl/vending_core_param_if.sv
// vending_core_param_if: coin/select/admin inputs and credit/stock/event outputs of the vending core.
interface vending_core_param_if #(
    parameter int NUM_PROD = 8,
    parameter int MONEY_W  = 12,
    parameter int STOCK_W  = 4
);
    localparam int IDX_W = $clog2(NUM_PROD);
    logic                        coin_valid;
    logic [MONEY_W-1:0]          coin_value;
    logic                        sel_valid;
    logic [IDX_W-1:0]            sel_idx;
    logic                        refund_req;
    logic                        admin_mode;
    logic                        restock_valid;
    logic [STOCK_W-1:0]          restock_val;
    logic                        price_we;
    logic [MONEY_W-1:0]          price_val;
    logic [MONEY_W-1:0]          credit;
    logic [NUM_PROD*STOCK_W-1:0] stock_flat;
    logic [NUM_PROD-1:0]         sold_out;
    logic                        vend_valid;
    logic [IDX_W-1:0]            vend_idx;
    logic                        coin_reject;
    logic [1:0]                  sel_err;
    logic                        change_big;
    logic                        change_small;
    logic                        change_done;
    logic                        busy;
    modport master (
        output coin_valid, coin_value, sel_valid, sel_idx, refund_req, admin_mode,
               restock_valid, restock_val, price_we, price_val,
        input  credit, stock_flat, sold_out, vend_valid, vend_idx, coin_reject, sel_err,
               change_big, change_small, change_done, busy
    );
    modport slave (
        input  coin_valid, coin_value, sel_valid, sel_idx, refund_req, admin_mode,
               restock_valid, restock_val, price_we, price_val,
        output credit, stock_flat, sold_out, vend_valid, vend_idx, coin_reject, sel_err,
               change_big, change_small, change_done, busy
    );
endinterface

// File: rtl/vending_core_param.sv
// vending_core_param: credit/stock/price core with vend and coin-by-coin change output.
// Optional inactivity auto-refund is enabled by defining AUTO_REFUND_EN.
module vending_core_param #(
    parameter int NUM_PROD       = 8,
    parameter int MONEY_W        = 12,
    parameter int STOCK_W        = 4,
    parameter int INIT_STOCK     = 5,
    parameter int DEFAULT_PRICE  = 50,
    parameter int BIG_COIN       = 50,
    parameter int SMALL_COIN     = 10,
    parameter int MAX_CREDIT     = 990,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input logic clk,
    input logic rst,
    vending_core_param_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_PROD);
    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;
    state_t             state, state_n;
    logic [MONEY_W-1:0] credit_q, credit_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [STOCK_W-1:0] stock [NUM_PROD];
    logic [MONEY_W-1:0] price [NUM_PROD];
    logic               coin_rej_q, coin_rej_n, done_q, done_n;
    logic [1:0]         err_q, err_n;
    logic [MONEY_W:0]   sum;
    logic               idle, idx_ok, coin_ok, do_refund, timeout, admin_wr;
    assign idle      = state == IDLE;
    assign idx_ok    = int'(bus.sel_idx) < NUM_PROD;
    assign sum       = {1'b0, credit_q} + {1'b0, bus.coin_value};
    assign coin_ok   = !bus.admin_mode && bus.coin_value % MONEY_W'(SMALL_COIN) == '0 &&
                       bus.coin_value != '0 && sum <= (MONEY_W+1)'(MAX_CREDIT);
    assign do_refund = idle && (bus.refund_req || timeout);
    assign admin_wr  = idle && bus.admin_mode && idx_ok;
`ifdef AUTO_REFUND_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] tmr;
    logic             tmr_run;
    // any coin/select/refund activity counts as an event that restarts the wait
    assign tmr_run = idle && credit_q != '0 && !bus.admin_mode &&
                     !bus.coin_valid && !bus.sel_valid && !bus.refund_req;
    assign timeout = tmr_run && tmr == TMR_W'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (!rst) tmr <= '0;
        else      tmr <= tmr_run && !timeout ? tmr + 1'b1 : '0;
    end
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_n    = state;
        credit_n   = credit_q;
        idx_n      = idx_q;
        coin_rej_n = bus.coin_valid;
        err_n      = bus.sel_valid ? 2'd3 : 2'd0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (do_refund) begin
                    done_n  = credit_q == '0;
                    state_n = credit_q == '0 ? IDLE : CHANGE;
                end else if (bus.sel_valid) begin
                    if (!bus.admin_mode && idx_ok) begin
                        err_n   = stock[bus.sel_idx] == '0 ? 2'd1 :
                                  credit_q < price[bus.sel_idx] ? 2'd2 : 2'd0;
                        state_n = err_n == 2'd0 ? VEND : IDLE;
                        idx_n   = bus.sel_idx;
                    end
                end else if (bus.coin_valid) begin
                    coin_rej_n = !coin_ok;
                    credit_n   = coin_ok ? sum[MONEY_W-1:0] : credit_q;
                end
            end
            VEND: begin
                credit_n = credit_q - price[idx_q];
                state_n  = IDLE;
            end
            CHANGE: begin
                state_n  = credit_q == '0 ? IDLE : CHANGE;
                credit_n = credit_q >= MONEY_W'(BIG_COIN)   ? credit_q - MONEY_W'(BIG_COIN) :
                           credit_q >= MONEY_W'(SMALL_COIN) ? credit_q - MONEY_W'(SMALL_COIN) : '0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            credit_q   <= '0;
            idx_q      <= '0;
            coin_rej_q <= 1'b0;
            err_q      <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            credit_q   <= credit_n;
            idx_q      <= idx_n;
            coin_rej_q <= coin_rej_n;
            err_q      <= err_n;
            done_q     <= done_n;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock[i] <= STOCK_W'(INIT_STOCK);
                price[i] <= MONEY_W'(DEFAULT_PRICE);
            end
        end else begin
            if (state == VEND) stock[idx_q] <= stock[idx_q] - 1'b1;
            if (admin_wr && bus.restock_valid) stock[bus.sel_idx] <= bus.restock_val;
            if (admin_wr && bus.price_we) price[bus.sel_idx] <= bus.price_val;
        end
    end
    for (genvar k = 0; k < NUM_PROD; k++) begin : g_stock
        assign bus.stock_flat[k*STOCK_W +: STOCK_W] = stock[k];
        assign bus.sold_out[k] = stock[k] == '0;
    end
    assign bus.credit       = credit_q;
    assign bus.vend_valid   = state == VEND;
    assign bus.vend_idx     = idx_q;
    assign bus.coin_reject  = coin_rej_q;
    assign bus.sel_err      = err_q;
    assign bus.change_big   = state == CHANGE && credit_q >= MONEY_W'(BIG_COIN);
    assign bus.change_small = state == CHANGE && credit_q != '0 && credit_q < MONEY_W'(BIG_COIN);
    assign bus.change_done  = (state == CHANGE && credit_q == '0) || done_q;
    assign bus.busy         = !idle;
endmodule

// File: tb/tb_vending_core_param.sv
// tb_vending_core_param: directed scenarios plus randomized transactions against a money/stock model.
module tb_vending_core_param;
    localparam int NP = 8, MW = 12, SW = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0, n_bad = 0;
    int m_credit;
    int m_stock [NP];
    int m_price [NP];
    vending_core_param_if #(.NUM_PROD(NP), .MONEY_W(MW), .STOCK_W(SW)) bus ();
    vending_core_param #(.NUM_PROD(NP), .MONEY_W(MW), .STOCK_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask
    task automatic clear_in();
        bus.coin_valid = 0; bus.coin_value = '0; bus.sel_valid = 0; bus.sel_idx = '0;
        bus.refund_req = 0; bus.admin_mode = 0; bus.restock_valid = 0; bus.restock_val = '0;
        bus.price_we = 0; bus.price_val = '0;
    endtask
    task automatic drive_coin(input int v);
        bus.coin_valid = 1; bus.coin_value = MW'(v);
        cycle(); clear_in();
    endtask
    task automatic drive_sel(input int k);
        bus.sel_valid = 1; bus.sel_idx = 3'(k);
        cycle(); clear_in();
    endtask
    task automatic drive_admin(input int k, input bit rs, input int sv, input bit pw, input int pv);
        bus.admin_mode = 1; bus.sel_idx = 3'(k);
        bus.restock_valid = rs; bus.restock_val = SW'(sv);
        bus.price_we = pw; bus.price_val = MW'(pv);
        cycle(); clear_in();
    endtask
    // issues a refund and counts emitted coins until change_done (bounded)
    task automatic run_refund(output int nb, output int ns, output bit done);
        bus.refund_req = 1;
        cycle(); clear_in();
        nb = 0; ns = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            nb += int'(bus.change_big);
            ns += int'(bus.change_small);
            done = bus.change_done;
            if (!done) cycle();
        end
        cycle();
    endtask
    function automatic logic [NP*SW-1:0] exp_flat();
        logic [NP*SW-1:0] r;
        for (int k = 0; k < NP; k++) r[k*SW +: SW] = SW'(m_stock[k]);
        return r;
    endfunction
    function automatic logic [NP-1:0] exp_sold();
        logic [NP-1:0] r;
        for (int k = 0; k < NP; k++) r[k] = m_stock[k] == 0;
        return r;
    endfunction
    task automatic model_reset();
        m_credit = 0;
        for (int k = 0; k < NP; k++) begin m_stock[k] = 5; m_price[k] = 50; end
    endtask
    task automatic test_reset();
        clear_in(); rst = 0;
        cycle(); cycle();
        rst = 1; model_reset();
        cycle();
        n_cmp++; if (bus.credit !== 12'd0) begin n_bad++; $display("FAIL reset_credit: got %0d exp 0", bus.credit); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b exp 0", bus.busy); end
        n_cmp++; if (bus.stock_flat !== exp_flat()) begin n_bad++; $display("FAIL reset_stock: got %h exp %h", bus.stock_flat, exp_flat()); end
        n_cmp++; if ({bus.vend_valid, bus.coin_reject, bus.sel_err, bus.change_big, bus.change_small, bus.change_done, bus.sold_out} !== 15'd0) begin
            n_bad++; $display("FAIL reset_pulses: got nonzero pulse/flag outputs exp 0"); end
    endtask
    task automatic test_vend();
        drive_coin(100);
        drive_coin(50);
        n_cmp++; if (bus.credit !== 12'd150 || bus.coin_reject !== 1'b0) begin n_bad++; $display("FAIL coin_accept: credit %0d rej %0b exp 150 0", bus.credit, bus.coin_reject); end
        drive_sel(3);
        n_cmp++; if (bus.vend_valid !== 1'b1 || bus.vend_idx !== 3'd3 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL vend_pulse: valid %0b idx %0d busy %0b exp 1 3 1", bus.vend_valid, bus.vend_idx, bus.busy); end
        cycle();
        n_cmp++; if (bus.credit !== 12'd100 || bus.stock_flat[15:12] !== 4'd4 || bus.vend_valid !== 1'b0) begin
            n_bad++; $display("FAIL vend_after: credit %0d stock3 %0d valid %0b exp 100 4 0", bus.credit, bus.stock_flat[15:12], bus.vend_valid); end
    endtask
    task automatic test_coin_reject();
        int nb, ns; bit dn;
        drive_coin(15);
        n_cmp++; if (bus.coin_reject !== 1'b1 || bus.credit !== 12'd100) begin n_bad++; $display("FAIL coin_15: rej %0b credit %0d exp 1 100", bus.coin_reject, bus.credit); end
        drive_coin(880);
        drive_coin(50);
        n_cmp++; if (bus.coin_reject !== 1'b1 || bus.credit !== 12'd980) begin n_bad++; $display("FAIL coin_over: rej %0b credit %0d exp 1 980", bus.coin_reject, bus.credit); end
        drive_coin(10);
        n_cmp++; if (bus.coin_reject !== 1'b0 || bus.credit !== 12'd990) begin n_bad++; $display("FAIL coin_max: rej %0b credit %0d exp 0 990", bus.coin_reject, bus.credit); end
        run_refund(nb, ns, dn);
        n_cmp++; if (nb != 19 || ns != 4 || !dn || bus.credit !== 12'd0) begin n_bad++; $display("FAIL refund_990: big %0d small %0d done %0b exp 19 4 1", nb, ns, dn); end
    endtask
    task automatic test_sel_errors();
        int nb, ns; bit dn;
        drive_coin(30);
        drive_sel(0);
        n_cmp++; if (bus.sel_err !== 2'd2 || bus.vend_valid !== 1'b0) begin n_bad++; $display("FAIL err_short: err %0d vend %0b exp 2 0", bus.sel_err, bus.vend_valid); end
        drive_admin(2, 1, 0, 0, 0);
        n_cmp++; if (bus.sold_out[2] !== 1'b1) begin n_bad++; $display("FAIL restock_zero: sold_out %b exp bit2 set", bus.sold_out); end
        drive_sel(2);
        n_cmp++; if (bus.sel_err !== 2'd1) begin n_bad++; $display("FAIL err_soldout: err %0d exp 1", bus.sel_err); end
        drive_admin(1, 1, 9, 1, 20);
        n_cmp++; if (bus.stock_flat[7:4] !== 4'd9) begin n_bad++; $display("FAIL restock_both: stock1 %0d exp 9", bus.stock_flat[7:4]); end
        drive_sel(1);
        cycle();
        n_cmp++; if (bus.credit !== 12'd10 || bus.stock_flat[7:4] !== 4'd8) begin n_bad++; $display("FAIL new_price: credit %0d stock1 %0d exp 10 8", bus.credit, bus.stock_flat[7:4]); end
        run_refund(nb, ns, dn);
    endtask
    task automatic test_refund();
        int seq = 0, expseq = 0;
        bit dn = 0;
        drive_coin(130);
        bus.refund_req = 1;
        cycle(); clear_in();
        for (int i = 0; i < 2; i++) expseq = expseq * 4 + 1;
        for (int i = 0; i < 3; i++) expseq = expseq * 4 + 2;
        expseq = expseq * 4 + 3;
        for (int i = 0; i < 20 && !dn; i++) begin
            seq = seq * 4 + (bus.change_done ? 3 : bus.change_big ? 1 : bus.change_small ? 2 : 0);
            dn = bus.change_done;
            if (!dn) cycle();
        end
        n_cmp++; if (seq != expseq) begin n_bad++; $display("FAIL refund_seq: got %0h exp %0h", seq, expseq); end
        cycle();
        n_cmp++; if (bus.busy !== 1'b0 || bus.credit !== 12'd0) begin n_bad++; $display("FAIL refund_end: busy %0b credit %0d exp 0 0", bus.busy, bus.credit); end
        bus.refund_req = 1;
        cycle(); clear_in();
        n_cmp++; if (bus.change_done !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL refund_zero: done %0b busy %0b exp 1 0", bus.change_done, bus.busy); end
    endtask
    task automatic test_collision();
        int nb, ns; bit dn;
        drive_coin(60);
        bus.sel_valid = 1; bus.sel_idx = 3'd4; bus.coin_valid = 1; bus.coin_value = 12'd50;
        cycle(); clear_in();
        n_cmp++; if (bus.vend_valid !== 1'b1 || bus.coin_reject !== 1'b1) begin n_bad++; $display("FAIL sel_coin: vend %0b rej %0b exp 1 1", bus.vend_valid, bus.coin_reject); end
        cycle();
        n_cmp++; if (bus.credit !== 12'd10) begin n_bad++; $display("FAIL sel_coin_credit: got %0d exp 10", bus.credit); end
        bus.refund_req = 1; bus.sel_valid = 1; bus.sel_idx = 3'd0;
        cycle(); clear_in();
        n_cmp++; if (bus.sel_err !== 2'd3 || bus.change_small !== 1'b1) begin n_bad++; $display("FAIL refund_sel: err %0d small %0b exp 3 1", bus.sel_err, bus.change_small); end
        cycle(); cycle();
        drive_coin(100);
        bus.refund_req = 1;
        cycle(); clear_in();
        drive_coin(50);
        n_cmp++; if (bus.coin_reject !== 1'b1 || bus.credit !== 12'd50 || bus.change_big !== 1'b1) begin
            n_bad++; $display("FAIL busy_coin: rej %0b credit %0d big %0b exp 1 50 1", bus.coin_reject, bus.credit, bus.change_big); end
        cycle(); cycle();
        run_refund(nb, ns, dn);
    endtask
    task automatic test_reset_mid_change();
        drive_coin(200);
        bus.refund_req = 1;
        cycle(); clear_in();
        cycle();
        rst = 0;
        cycle();
        rst = 1; model_reset();
        n_cmp++; if (bus.busy !== 1'b0 || bus.credit !== 12'd0 || bus.change_done !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: busy %0b credit %0d done %0b exp 0 0 0", bus.busy, bus.credit, bus.change_done); end
        cycle();
        n_cmp++; if (bus.stock_flat !== exp_flat() || bus.change_done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stock: got %h exp %h", bus.stock_flat, exp_flat()); end
    endtask
    task automatic test_random();
        for (int it = 0; it < 200; it++) begin
            int op = $urandom_range(0, 9);
            if (op <= 3) begin
                int r = $urandom_range(0, 3);
                int v = r == 0 ? $urandom_range(1, 30) * 10 : r == 1 ? $urandom_range(0, 99) : r == 2 ? 500 : 0;
                bit ok = v % 10 == 0 && v != 0 && m_credit + v <= 990;
                drive_coin(v);
                if (ok) m_credit += v;
                n_cmp++; if (bus.coin_reject !== !ok || bus.credit !== MW'(m_credit)) begin
                    n_bad++; $display("FAIL rnd_coin: v %0d rej %0b credit %0d exp %0b %0d", v, bus.coin_reject, bus.credit, !ok, m_credit); end
            end else if (op <= 6) begin
                int k = $urandom_range(0, NP - 1);
                int e = m_stock[k] == 0 ? 1 : m_credit < m_price[k] ? 2 : 0;
                drive_sel(k);
                n_cmp++; if (bus.sel_err !== 2'(e) || bus.vend_valid !== (e == 0) || (e == 0 && bus.vend_idx !== 3'(k))) begin
                    n_bad++; $display("FAIL rnd_sel: k %0d err %0d vend %0b idx %0d exp %0d", k, bus.sel_err, bus.vend_valid, bus.vend_idx, e); end
                if (e == 0) begin
                    cycle();
                    m_credit -= m_price[k]; m_stock[k]--;
                    n_cmp++; if (bus.credit !== MW'(m_credit) || bus.stock_flat !== exp_flat()) begin
                        n_bad++; $display("FAIL rnd_vend: credit %0d stock %h exp %0d %h", bus.credit, bus.stock_flat, m_credit, exp_flat()); end
                end
            end else if (op == 7) begin
                int nb, ns; bit dn;
                run_refund(nb, ns, dn);
                n_cmp++; if (nb != m_credit / 50 || ns != (m_credit % 50) / 10 || !dn || bus.credit !== 12'd0 || bus.busy !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_refund: big %0d small %0d done %0b from credit %0d", nb, ns, dn, m_credit); end
                m_credit = 0;
            end else begin
                int k = $urandom_range(0, NP - 1);
                bit rs = 1'($urandom_range(0, 1));
                bit pw = !rs || 1'($urandom_range(0, 1));
                int sv = $urandom_range(0, 15);
                int pv = $urandom_range(1, 20) * 10;
                drive_admin(k, rs, sv, pw, pv);
                if (rs) m_stock[k] = sv;
                if (pw) m_price[k] = pv;
                n_cmp++; if (bus.stock_flat !== exp_flat() || bus.sold_out !== exp_sold()) begin
                    n_bad++; $display("FAIL rnd_admin: stock %h sold %b exp %h %b", bus.stock_flat, bus.sold_out, exp_flat(), exp_sold()); end
            end
        end
    endtask
    initial begin
        test_reset();
        test_vend();
        test_coin_reject();
        test_sel_errors();
        test_refund();
        test_collision();
        test_reset_mid_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vending_core_param.md
Name: vending_core_param

Overview:
Parametrised vending-machine transaction core for NUM_PROD products. It accumulates coin credit, checks price and stock on each selection, and issues vend pulses. On refund it returns change as a cycle-by-cycle stream of large and small coins. It sits between the one-shot button/coin decode and the display, piezo, LED and LCD drivers, and feeds them credit, stock and event pulses.

Parameters:
NUM_PROD, 8, number of products (2..16)
MONEY_W, 12, width of credit and price values (units of 10 won)
STOCK_W, 4, per-product stock counter width
INIT_STOCK, 5, stock of every product after reset
DEFAULT_PRICE, 50, price of every product after reset
BIG_COIN, 50, large change-coin value
SMALL_COIN, 10, small change-coin value; every accepted credit is a multiple of this
MAX_CREDIT, 990, credit ceiling
TIMEOUT_CYCLES, 50_000_000, inactivity limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
coin_valid  in  1  one-cycle pulse: coin inserted
coin_value  in  MONEY_W  value of the inserted coin
sel_valid  in  1  one-cycle pulse: product selected
sel_idx  in  $clog2(NUM_PROD)  selected product
refund_req  in  1  one-cycle pulse: return credit
admin_mode  in  1  level: maintenance mode
restock_valid  in  1  admin pulse: set stock of sel_idx to restock_val
restock_val  in  STOCK_W  new stock value
price_we  in  1  admin pulse: set price of sel_idx to price_val
price_val  in  MONEY_W  new price
credit  out  MONEY_W  current credit
stock_flat  out  NUM_PROD*STOCK_W  all stock counters; product k at [k*STOCK_W +: STOCK_W]
sold_out  out  NUM_PROD  bit k is 1 when stock[k]==0
vend_valid  out  1  one-cycle pulse: product dispensed
vend_idx  out  $clog2(NUM_PROD)  product index, valid with vend_valid
coin_reject  out  1  one-cycle pulse: inserted coin not accepted
sel_err  out  2  one-cycle error code: 0 none, 1 sold out, 2 short credit, 3 bad index/busy
change_big  out  1  one-cycle pulse: emit one BIG_COIN
change_small  out  1  one-cycle pulse: emit one SMALL_COIN
change_done  out  1  one-cycle pulse: refund complete
busy  out  1  1 in states VEND and CHANGE

Behaviour:
- Reset (rst==0 at a clk edge):
  - State is IDLE; credit is 0.
  - Every stock is INIT_STOCK; every price is DEFAULT_PRICE.
  - All pulse outputs are 0; sel_err is 0; busy is 0.
  - Reset taken mid-CHANGE abandons the refund; no change_done is issued.
- FSM states: IDLE, VEND, CHANGE.
- IDLE, same-cycle input priority: refund_req > sel_valid > coin_valid. Each lower-priority input that loses in that cycle produces coin_reject or sel_err=3.
- Coin, accepted when not admin_mode, coin_value%SMALL_COIN==0, coin_value!=0, and credit+coin_value<=MAX_CREDIT:
  - credit updates on the next cycle.
  - Otherwise coin_reject pulses and credit is unchanged.
  - The sum is computed at MONEY_W+1 bits so overflow is detected.
- Selection when not admin_mode, checks in this order:
  - sel_idx>=NUM_PROD gives sel_err=3.
  - stock==0 gives sel_err=1.
  - credit<price gives sel_err=2.
  - Otherwise go to VEND.
- VEND lasts exactly one cycle:
  - vend_valid=1 and vend_idx is the latched index.
  - The stock decrements and credit-=price.
  - Returns to IDLE. Latency from sel_valid to vend_valid is 1 cycle.
- Refund: if credit==0, change_done pulses the next cycle and state stays IDLE; otherwise go to CHANGE.
- CHANGE emits one coin per cycle:
  - if credit>=BIG_COIN: change_big, credit-=BIG_COIN
  - else: change_small, credit-=SMALL_COIN
  - When credit reaches 0: change_done pulses in the following cycle, then IDLE.
- In VEND and CHANGE, all coin, sel, refund and admin inputs are ignored: coins produce coin_reject, selections produce sel_err=3.
- Admin mode, IDLE only:
  - restock_valid writes the stock.
  - price_we writes the price.
  - If both arrive together, both are applied.
  - Out-of-range sel_idx makes the write ignored.
  - Selections in admin mode produce sel_err=3; coins are rejected.
  - refund_req is still honoured.
- sold_out and stock_flat are registered and follow the stock values with no extra cycle of delay.

Optional Feature:
AUTO_REFUND_EN
- Defined:
  - A timer counts IDLE cycles while credit!=0 and admin_mode==0.
  - Any accepted coin, vend, or error event clears it.
  - Reaching TIMEOUT_CYCLES enters CHANGE exactly as refund_req would.
- Undefined: no timer logic; credit is held indefinitely.

Test Plan:
- Reset, then coins 100 + 50 -> credit=150 with no coin_reject; sel 3 -> vend_valid with vend_idx=3 one cycle later, credit=100, stock[3]=4.
- Coin 15 -> coin_reject, credit unchanged. Credit 980 plus coin 50 -> coin_reject, credit stays 980.
- Credit 30, sel 0 at price 50 -> sel_err=2. Admin restock product 2 to 0, then sel 2 -> sel_err=1 and sold_out[2]=1.
- Credit 130, refund -> change_big, change_big, change_small, change_small, change_small on consecutive cycles, then change_done; credit=0 and busy deasserts.
- sel_valid and coin_valid in the same IDLE cycle -> selection handled, coin_reject pulses. rst=0 during CHANGE -> credit=0, state IDLE, all stock=5.
- With AUTO_REFUND_EN and TIMEOUT_CYCLES=20: credit 60, idle 20 cycles -> change_big, change_small, change_done.
